// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multiply/divide sequencer.
//   - MIPS R-type funct codes served by the HI/LO unit
//   - sequencer state enum and datapath mode enum
//   - funct classification helpers
package mips_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } dp_mode_t;

  // Functs that start a multi-cycle operation.
  function automatic logic fn_is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  // Every funct owned by this unit; only these may stall the pipeline.
  function automatic logic fn_is_known(input logic [5:0] fn);
    return fn_is_muldiv(fn) || (fn == FN_MFHI) || (fn == FN_MTHI) ||
           (fn == FN_MFLO) || (fn == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: 2*WIDTH accumulator with one radix-2 multiply step
// (shift-add) or one restoring divide step (shift-subtract) per enabled cycle.
// Operands are unsigned magnitudes; sign handling lives in the sequencer.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_load            capture magnitudes and mode, initialise accumulator
//   i_step            perform one iteration in the captured mode
//   i_mode            MODE_MUL / MODE_DIV, sampled with i_load
//   i_mag_a, i_mag_b  multiplicand/dividend and multiplier/divisor magnitudes
//   o_hi, o_lo        raw accumulator halves (product, or remainder/quotient)
//   o_mplier_done     the step about to run leaves the multiplier at zero
module muldiv_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  dp_mode_t         i_mode,
  input  logic [WIDTH-1:0] i_mag_a,
  input  logic [WIDTH-1:0] i_mag_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_mplier_done
);

  logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
  logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]   r_opb, w_opb_nxt;
  dp_mode_t           r_mode;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;

  // Divide: partial remainder shifted left by one with the next dividend bit.
  // The subtraction is kept to WIDTH bits; when it is taken the true result
  // always fits, and with a zero divisor the truncation makes HI end up
  // holding the dividend.
  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opb;

  always_comb begin
    w_acc_nxt   = r_acc;
    w_mcand_nxt = r_mcand;
    w_opb_nxt   = r_opb;
    if (i_load) begin
      w_acc_nxt   = (i_mode == MODE_DIV) ? {{WIDTH{1'b0}}, i_mag_a} : '0;
      w_mcand_nxt = {{WIDTH{1'b0}}, i_mag_a};
      w_opb_nxt   = i_mag_b;
    end else if (i_step) begin
      if (r_mode == MODE_MUL) begin
        // Multiplicand shifts left so the product needs no realignment
        // when the multiply ends early.
        if (r_opb[0]) begin
          w_acc_nxt = r_acc + r_mcand;
        end
        w_mcand_nxt = {r_mcand[2*WIDTH-2:0], 1'b0};
        w_opb_nxt   = {1'b0, r_opb[WIDTH-1:1]};
      end else begin
        if (w_rem_sh >= {1'b0, r_opb}) begin
          w_acc_nxt = {w_diff, r_acc[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_opb   <= '0;
      r_mode  <= MODE_MUL;
    end else begin
      r_acc   <= w_acc_nxt;
      r_mcand <= w_mcand_nxt;
      r_opb   <= w_opb_nxt;
      if (i_load) begin
        r_mode <= i_mode;
      end
    end
  end

  assign o_hi          = r_acc[2*WIDTH-1:WIDTH];
  assign o_lo          = r_acc[WIDTH-1:0];
  assign o_mplier_done = (r_opb[WIDTH-1:1] == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO,
// serving MFHI/MFLO/MTHI/MTLO and stalling the pipeline while busy.
// Build option: MULDIV_EARLY_OUT_EN -- multiplies stop once the remaining
// multiplier magnitude is zero (at least one iteration); divides always run
// WIDTH iterations.
// Ports:
//   Clk, Reset_n          clock, async active-low reset
//   Start, FuncCode       EX-stage R-type op and its funct field
//   OperandA, OperandB    rs / rt values
//   Flush                 squash any in-flight op
//   Stall                 known funct presented while busy
//   Result                HI for MFHI, LO for MFLO (when idle), else 0
//   Hi, Lo                architectural HI/LO registers
//   Busy                  operation in flight
//   Done, DivByZero       one-cycle pulses after HI/LO are written
//
// state | meaning
// IDLE  | waiting; MTxx/MFxx served, mul/div accepted
// MUL   | shift-add iterations
// DIV   | restoring shift-subtract iterations
// FIX   | sign correction, HI/LO write
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Stall,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY_OUT = 1'b1;
`else
  localparam logic EARLY_OUT = 1'b0;
`endif

  muldiv_state_t      r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz_pulse;
  logic               r_div_op, r_div_zero, r_neg_lo, r_neg_hi;

  logic               w_idle, w_accept, w_load, w_step, w_last, w_fix_wr;
  logic               w_div_fn, w_signed_fn, w_sa, w_sb;
  logic               w_mthi, w_mtlo;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH-1:0]   w_dp_hi, w_dp_lo;
  logic               w_mplier_done;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_idle      = (r_state == IDLE);
  assign w_div_fn    = (FuncCode == FN_DIV) || (FuncCode == FN_DIVU);
  assign w_signed_fn = (FuncCode == FN_MULT) || (FuncCode == FN_DIV);
  assign w_sa        = w_signed_fn & OperandA[WIDTH-1];
  assign w_sb        = w_signed_fn & OperandB[WIDTH-1];
  assign w_mag_a     = w_sa ? -OperandA : OperandA;
  assign w_mag_b     = w_sb ? -OperandB : OperandB;

  assign w_accept = Start & w_idle & ~Flush & fn_is_muldiv(FuncCode);
  assign w_mthi   = Start & w_idle & ~Flush & (FuncCode == FN_MTHI);
  assign w_mtlo   = Start & w_idle & ~Flush & (FuncCode == FN_MTLO);
  assign w_fix_wr = (r_state == FIX) & ~Flush;

  assign w_last = (r_cnt == CW'(1)) |
                  (EARLY_OUT & (r_state == MUL) & w_mplier_done);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    if (Flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_load      = 1'b1;
            w_state_nxt = w_div_fn ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          w_step = 1'b1;
          if (w_last) begin
            w_state_nxt = FIX;
          end
        end
        FIX:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .i_clk         (Clk),
    .i_rst_n       (Reset_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_mode        (w_div_fn ? MODE_DIV : MODE_MUL),
    .i_mag_a       (w_mag_a),
    .i_mag_b       (w_mag_b),
    .o_hi          (w_dp_hi),
    .o_lo          (w_dp_lo),
    .o_mplier_done (w_mplier_done)
  );

  // Products are negated as one 2*WIDTH value; quotient and remainder are
  // corrected independently (remainder follows the dividend's sign).
  assign w_prod     = {w_dp_hi, w_dp_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;

  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
    if (r_div_op) begin
      w_fix_hi = r_neg_hi ? -w_dp_hi : w_dp_hi;
      w_fix_lo = r_div_zero ? {WIDTH{1'b1}} : (r_neg_lo ? -w_dp_lo : w_dp_lo);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      r_div_op    <= 1'b0;
      r_div_zero  <= 1'b0;
      r_neg_lo    <= 1'b0;
      r_neg_hi    <= 1'b0;
    end else begin
      r_done      <= w_fix_wr;
      r_dbz_pulse <= w_fix_wr & r_div_zero;

      if (Flush) begin
        r_cnt <= '0;
      end else if (w_load) begin
        r_cnt <= CW'(WIDTH);
      end else if (w_step) begin
        r_cnt <= w_last ? '0 : r_cnt - CW'(1);
      end

      if (w_load) begin
        r_div_op   <= w_div_fn;
        r_div_zero <= w_div_fn & (OperandB == '0);
        r_neg_lo   <= w_sa ^ w_sb;
        r_neg_hi   <= w_div_fn ? w_sa : (w_sa ^ w_sb);
      end

      if (w_fix_wr) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else begin
        if (w_mthi) r_hi <= OperandA;
        if (w_mtlo) r_lo <= OperandA;
      end
    end
  end

  always_comb begin
    Result = '0;
    if (Start && w_idle) begin
      case (FuncCode)
        FN_MFHI: Result = r_hi;
        FN_MFLO: Result = r_lo;
        default: Result = '0;
      endcase
    end
  end

  assign Stall     = Start & fn_is_known(FuncCode) & ~w_idle;
  assign Busy      = ~w_idle;
  assign Hi        = r_hi;
  assign Lo        = r_lo;
  assign Done      = r_done;
  assign DivByZero = r_dbz_pulse;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import mips_pkg::*;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          Start = 1'b0;
  logic [5:0]    FuncCode = '0;
  logic [W-1:0]  OperandA = '0;
  logic [W-1:0]  OperandB = '0;
  logic          Flush = 1'b0;
  logic          Stall, Busy, Done, DivByZero;
  logic [W-1:0]  Result, Hi, Lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .FuncCode(FuncCode),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .Stall(Stall), .Result(Result), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  // Reference: {HI, LO} from plain wide arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (fn)
      FN_MULTU: p = {32'd0, a} * {32'd0, b};
      FN_MULT:  p = 64'(sa * sb);
      FN_DIVU:  p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      FN_DIV: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Reference: number of iterations before the fix-up cycle.
  function automatic int ref_iters(input logic [5:0] fn, input logic [31:0] b);
    int n;
    logic [31:0] mag;
    n = W;
    mag = (fn == FN_MULT && b[31]) ? (32'd0 - b) : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (fn == FN_MULT || fn == FN_MULTU) begin
      n = 1;
      for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
    end
`else
    if (mag == 32'hFFFF_FFFF && n == 0) n = 0;
`endif
    return n;
  endfunction

  // Issue one mul/div and observe it until Done (bounded).
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int done_edge, output int busy_cyc, output logic extra);
    hi = '0; lo = '0; dbz = 1'b0; done_edge = -1; busy_cyc = 0; extra = 1'b0;
    @(negedge Clk);
    Start = 1'b1; FuncCode = fn; OperandA = a; OperandB = b;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; FuncCode = 6'h00;
    if (Busy) busy_cyc++;
    for (int e = 1; e <= 200; e++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Busy) busy_cyc++;
      if (Done) begin
        done_edge = e; hi = Hi; lo = Lo; dbz = DivByZero;
        break;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    extra = Done | DivByZero;
  endtask

  task automatic mt_write(input logic [5:0] fn, input logic [31:0] v);
    @(negedge Clk);
    Start = 1'b1; FuncCode = fn; OperandA = v;
    @(negedge Clk);
    Start = 1'b0; FuncCode = 6'h00;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({Hi, Lo, Busy, Done, DivByZero, Stall, Result} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: Hi=%h Lo=%h Busy=%b Done=%b Dbz=%b, required all zero", Hi, Lo, Busy, Done, DivByZero);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({Hi, Lo, Busy, Done} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: Hi=%h Lo=%h Busy=%b Done=%b, required all zero", Hi, Lo, Busy, Done);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  fns [9] = '{FN_MULTU, FN_MULT, FN_MULTU, FN_MULTU, FN_DIV, FN_DIVU, FN_DIV, FN_DIV, FN_DIV};
    logic [31:0] as  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd5, 32'd5, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFF9};
    logic [31:0] bs  [9] = '{32'hFFFFFFFF, 32'd7, 32'd3, 32'd0, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0};
    logic [64:0] exp [9] = '{{64'hFFFFFFFE_00000001, 1'b0}, {64'hFFFFFFFF_FFFFFFEB, 1'b0},
                             {64'h00000000_0000000F, 1'b0}, {64'h0, 1'b0},
                             {64'hFFFFFFFF_FFFFFFFD, 1'b0}, {64'h00000007_FFFFFFFF, 1'b1},
                             {64'h00000000_80000000, 1'b0}, {64'h00000001_FFFFFFFD, 1'b0},
                             {64'hFFFFFFF9_FFFFFFFF, 1'b1}};
    logic [31:0] hi, lo;
    logic dbz, extra;
    int de, bc, n;
    for (int i = 0; i < 9; i++) begin
      run_op(fns[i], as[i], bs[i], hi, lo, dbz, de, bc, extra);
      n = ref_iters(fns[i], bs[i]);
      n_cmp++;
      if ({hi, lo, dbz} !== exp[i]) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got hi=%h lo=%h dbz=%b, required %h", i, hi, lo, dbz, exp[i]);
      end
      n_cmp++;
      if (de !== n + 1 || bc !== n + 1) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: done_edge=%0d busy=%0d, required %0d", i, de, bc, n + 1);
      end
      n_cmp++;
      if (extra !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_pulse[%0d]: Done/Dbz still high after one cycle, required 0", i);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  fn;
    logic [31:0] a, b, hi, lo;
    logic [63:0] e;
    logic dbz, extra;
    int de, bc, n;
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 3))
        0: fn = FN_MULT;
        1: fn = FN_MULTU;
        2: fn = FN_DIV;
        default: fn = FN_DIVU;
      endcase
      a = pick_operand();
      b = pick_operand();
      run_op(fn, a, b, hi, lo, dbz, de, bc, extra);
      e = ref_hilo(fn, a, b);
      n = ref_iters(fn, b);
      n_cmp++;
      if ({hi, lo} !== e || dbz !== ((fn == FN_DIV || fn == FN_DIVU) && b == 0)) begin
        n_bad++;
        $display("FAIL random_result fn=%h a=%h b=%h: got %h_%h dbz=%b, required %h", fn, a, b, hi, lo, dbz, e);
      end
      n_cmp++;
      if (de !== n + 1 || bc !== n + 1 || extra !== 1'b0) begin
        n_bad++;
        $display("FAIL random_timing fn=%h b=%h: done_edge=%0d busy=%0d extra=%b, required %0d", fn, b, de, bc, extra, n + 1);
      end
    end
  endtask

  task automatic test_mt_mf();
    mt_write(FN_MTHI, 32'h0000_1234);
    mt_write(FN_MTLO, 32'h0000_5678);
    n_cmp++;
    if ({Hi, Lo} !== 64'h00001234_00005678) begin
      n_bad++;
      $display("FAIL mthi_mtlo: Hi=%h Lo=%h, required 00001234 00005678", Hi, Lo);
    end
    @(negedge Clk);
    Start = 1'b1; FuncCode = FN_MFHI;
    #1;
    n_cmp++;
    if (Result !== 32'h1234 || Stall !== 1'b0) begin
      n_bad++;
      $display("FAIL mfhi: Result=%h Stall=%b, required 00001234 0", Result, Stall);
    end
    FuncCode = FN_MFLO;
    #1;
    n_cmp++;
    if (Result !== 32'h5678) begin
      n_bad++;
      $display("FAIL mflo: Result=%h, required 00005678", Result);
    end
    // Unlisted funct while idle: no effect.
    @(negedge Clk);
    FuncCode = 6'h20; OperandA = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0;
    n_cmp++;
    if ({Hi, Lo, Busy, Stall} !== {64'h00001234_00005678, 2'b00}) begin
      n_bad++;
      $display("FAIL unlisted_idle: Hi=%h Lo=%h Busy=%b Stall=%b, required unchanged/0", Hi, Lo, Busy, Stall);
    end
  endtask

  task automatic test_mf_stall();
    logic [63:0] e;
    logic seen;
    int bad;
    e = ref_hilo(FN_MULT, 32'hFFFF_0123, 32'h4000_0001);
    @(negedge Clk);
    Start = 1'b1; FuncCode = FN_MULT; OperandA = 32'hFFFF_0123; OperandB = 32'h4000_0001;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Start = 1'b1; FuncCode = FN_MFLO;
    seen = 1'b0; bad = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (Done) begin seen = 1'b1; break; end
      if (Stall !== 1'b1) bad++;
      @(negedge Clk);
    end
    n_cmp++;
    if (!seen || bad != 0) begin
      n_bad++;
      $display("FAIL mf_stall: done_seen=%b unstalled_cycles=%0d, required 1 and 0", seen, bad);
    end
    n_cmp++;
    if (Result !== e[31:0] || Stall !== 1'b0) begin
      n_bad++;
      $display("FAIL mf_done_read: Result=%h Stall=%b, required %h 0", Result, Stall, e[31:0]);
    end
    @(negedge Clk);
    Start = 1'b0; FuncCode = 6'h00;
  endtask

  task automatic test_busy_ignore();
    logic [63:0] e;
    logic seen;
    e = ref_hilo(FN_MULTU, 32'h0ABC_DEF1, 32'h8765_4321);
    @(negedge Clk);
    Start = 1'b1; FuncCode = FN_MULTU; OperandA = 32'h0ABC_DEF1; OperandB = 32'h8765_4321;
    @(negedge Clk);
    FuncCode = FN_MTHI; OperandA = 32'hDEAD_0000;
    @(negedge Clk);
    n_cmp++;
    if (Stall !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_mthi_busy: Stall=%b, required 1", Stall);
    end
    FuncCode = 6'h20;
    #1;
    n_cmp++;
    if (Stall !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_unlisted_busy: Stall=%b, required 0", Stall);
    end
    @(negedge Clk);
    FuncCode = FN_DIV; OperandB = 32'd3;
    #1;
    n_cmp++;
    if (Stall !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_div_busy: Stall=%b, required 1", Stall);
    end
    @(negedge Clk);
    Start = 1'b0; FuncCode = 6'h00;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (Done) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    n_cmp++;
    if (!seen || {Hi, Lo} !== e) begin
      n_bad++;
      $display("FAIL busy_ignore_result: done=%b got %h_%h, required %h", seen, Hi, Lo, e);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_flush();
    logic seen;
    mt_write(FN_MTHI, 32'hAAAA_0001);
    mt_write(FN_MTLO, 32'hBBBB_0002);
    @(negedge Clk);
    Start = 1'b1; FuncCode = FN_DIV; OperandA = 32'h1234_5678; OperandB = 32'd9;
    @(negedge Clk);
    Start = 1'b0; FuncCode = 6'h00;
    repeat (9) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_busy: Busy=%b, required 0", Busy);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    n_cmp++;
    if (seen || {Hi, Lo} !== 64'hAAAA0001_BBBB0002) begin
      n_bad++;
      $display("FAIL flush_hilo: done_seen=%b Hi=%h Lo=%h, required 0 AAAA0001 BBBB0002", seen, Hi, Lo);
    end
    @(negedge Clk);
    Start = 1'b1; FuncCode = FN_MULTU; OperandA = 32'd3; Flush = 1'b1;
    @(negedge Clk);
    FuncCode = FN_MTHI; OperandA = 32'hFFFF_0000;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0; FuncCode = 6'h00;
    n_cmp++;
    if (Busy !== 1'b0 || Hi !== 32'hAAAA_0001) begin
      n_bad++;
      $display("FAIL flush_with_start: Busy=%b Hi=%h, required 0 AAAA0001", Busy, Hi);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] hi, lo;
    logic dbz, extra;
    int de, bc;
    mt_write(FN_MTHI, 32'h55);
    @(negedge Clk);
    Start = 1'b1; FuncCode = FN_MULT; OperandA = 32'hFFFF_FFF0; OperandB = 32'h7000_0003;
    @(negedge Clk);
    Start = 1'b0; FuncCode = 6'h00;
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({Hi, Lo, Busy, Done} !== '0) begin
      n_bad++;
      $display("FAIL reset_midop: Hi=%h Lo=%h Busy=%b Done=%b, required all zero", Hi, Lo, Busy, Done);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(FN_MULTU, 32'd6, 32'd7, hi, lo, dbz, de, bc, extra);
    n_cmp++;
    if ({hi, lo} !== 64'd42 || de !== ref_iters(FN_MULTU, 32'd7) + 1) begin
      n_bad++;
      $display("FAIL after_reset_op: got %h_%h done_edge=%0d, required 42 at %0d", hi, lo, de, ref_iters(FN_MULTU, 32'd7) + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t, required finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_mt_mf();
    test_mf_stall();
    test_busy_ignore();
    test_flush();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
